// File: rtl/multicycle_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_pkg
//   Shared types and constants for the multicycle RV32I control sequencer:
//   FSM state encoding, ALU operation codes, RV32I opcode and branch funct3
//   values, datapath mux-select codes, the registered control word, and the
//   funct3/funct7 -> ALU operation decoder.
// ---------------------------------------------------------------------------
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_FAULT   = 4'd11
  } ctrl_state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SRCA_RS1   = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_ZERO  = 2'd2;
  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;
  localparam logic [1:0] RES_ALU    = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_PC4    = 2'd2;

  // Registered control word. jump/branch are kept separate so that the
  // branch decision can use the ALU flags of the BRANCH cycle itself.
  typedef struct packed {
    logic       ir_write;
    logic       pc_update;
    logic       jump;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_control;
    logic [1:0] result_src;
    logic       retire;
    logic       illegal;
  } ctrl_word_t;

  // funct7_5 only selects SUB for register-register ops; for OP-IMM it is an
  // immediate bit except on the shift-right pair.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                         input logic       funct7_5,
                                         input logic       is_reg);
    alu_op_t op;
    unique case (funct3)
      3'b000:  op = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_if
//   Bundle between the control sequencer and the rest of the core.
//   master : sequencer side (decode fields + ALU flags in, controls out)
//   slave  : datapath side (mirror image)
//   Signals: opcode, funct3, funct7_5, alu_zero_flag, alu_lt_flag,
//   alu_ltu_flag, ir_write, pc_update, pc_src, reg_write, mem_write,
//   alu_src_a, alu_src_b, alu_control, result_src, retire, instret,
//   illegal_instr.
// ---------------------------------------------------------------------------
interface multicycle_control_fsm_if #(parameter int INSTRET_W = 32);
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 funct7_5;
  logic                 alu_zero_flag;
  logic                 alu_lt_flag;
  logic                 alu_ltu_flag;
  logic                 ir_write;
  logic                 pc_update;
  logic                 pc_src;
  logic                 reg_write;
  logic                 mem_write;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [3:0]           alu_control;
  logic [1:0]           result_src;
  logic                 retire;
  logic [INSTRET_W-1:0] instret;
  logic                 illegal_instr;

  modport master (
    input  opcode, funct3, funct7_5, alu_zero_flag, alu_lt_flag, alu_ltu_flag,
    output ir_write, pc_update, pc_src, reg_write, mem_write, alu_src_a,
           alu_src_b, alu_control, result_src, retire, instret, illegal_instr
  );

  modport slave (
    output opcode, funct3, funct7_5, alu_zero_flag, alu_lt_flag, alu_ltu_flag,
    input  ir_write, pc_update, pc_src, reg_write, mem_write, alu_src_a,
           alu_src_b, alu_control, result_src, retire, instret, illegal_instr
  );
endinterface

// File: rtl/multicycle_control_fsm_branch_resolver.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_branch_resolver
//   Combinational branch condition evaluation.
//   funct3_i : branch funct3
//   zero_i / lt_i / ltu_i : ALU flags from rs1 - rs2
//   taken_o  : condition true
//   legal_o  : funct3 is one of the six RV32I branch codes
// ---------------------------------------------------------------------------
module multicycle_control_fsm_branch_resolver
  import multicycle_control_fsm_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       taken_o,
  output logic       legal_o
);

  always_comb begin
    taken_o = 1'b0;
    legal_o = 1'b1;
    unique case (funct3_i)
      F3_BEQ:  taken_o = zero_i;
      F3_BNE:  taken_o = ~zero_i;
      F3_BLT:  taken_o = lt_i;
      F3_BGE:  taken_o = ~lt_i;
      F3_BLTU: taken_o = ltu_i;
      F3_BGEU: taken_o = ~ltu_i;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Main sequencer of the multicycle RV32I core. Steps each instruction
//   through FETCH/DECODE/EXECUTE/MEM/WB, drives fetch, register file, ALU and
//   data-memory controls, resolves branches, pulses retire and counts
//   retired instructions.
//   clk   : core clock
//   reset : synchronous, active-high; all outputs forced to 0 while high
//   bus   : multicycle_control_fsm_if.master (decode fields, flags, controls)
// ---------------------------------------------------------------------------
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_control_fsm_if.master      bus
);

  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  ctrl_state_t          state_q, state_d;
  ctrl_word_t           ctrl_q, ctrl_d, ctrl_o;
  logic [INSTRET_W-1:0] instret_q;
  logic                 br_taken, br_legal;

  multicycle_control_fsm_branch_resolver u_branch_resolver (
    .funct3_i (bus.funct3),
    .zero_i   (bus.alu_zero_flag),
    .lt_i     (bus.alu_lt_flag),
    .ltu_i    (bus.alu_ltu_flag),
    .taken_o  (br_taken),
    .legal_o  (br_legal)
  );

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_IMM, OP_LUI:    state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_BRANCH:         state_d = br_legal ? S_BRANCH : S_FAULT;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FAULT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_ADR: state_d = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = S_MEM_WB;
      S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL: state_d = S_FETCH;
      default:   state_d = S_FAULT;
    endcase
  end

  // Control word for the state being entered; registered with the state
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_FETCH:  ctrl_d.ir_write = 1'b1;
      S_EXEC_R: begin
        ctrl_d.alu_src_b   = SRCB_RS2;
        ctrl_d.alu_control = alu_decode(bus.funct3, bus.funct7_5, 1'b1);
      end
      S_EXEC_I: begin
        ctrl_d.alu_src_b = SRCB_IMM;
        if (bus.opcode == OP_LUI) begin
          ctrl_d.alu_src_a   = SRCA_ZERO;
          ctrl_d.alu_control = ALU_ADD;
        end else begin
          ctrl_d.alu_control = alu_decode(bus.funct3, bus.funct7_5, 1'b0);
        end
      end
      S_ALU_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = RES_ALU;
        ctrl_d.pc_update  = 1'b1;
        ctrl_d.retire     = 1'b1;
      end
      S_MEM_ADR: begin
        ctrl_d.alu_src_b   = SRCB_IMM;
        ctrl_d.alu_control = ALU_ADD;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = RES_MEM;
        ctrl_d.pc_update  = 1'b1;
        ctrl_d.retire     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.pc_update = 1'b1;
        ctrl_d.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a   = SRCA_RS1;
        ctrl_d.alu_src_b   = SRCB_RS2;
        ctrl_d.alu_control = ALU_SUB;
        ctrl_d.branch      = 1'b1;
        ctrl_d.pc_update   = 1'b1;
        ctrl_d.retire      = 1'b1;
      end
      S_JAL: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = RES_PC4;
        ctrl_d.pc_update  = 1'b1;
        ctrl_d.jump       = 1'b1;
        ctrl_d.retire     = 1'b1;
      end
      S_FAULT:  ctrl_d.illegal = 1'b1;
      default:  ctrl_d = '0;
    endcase
  end

  // State, control word and retire counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_FETCH;
      ctrl_q          <= '0;
      ctrl_q.ir_write <= 1'b1;
      instret_q       <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      if (ctrl_q.retire) begin
        instret_q <= instret_q + INSTRET_ONE;
      end
    end
  end

  // Reset gates every output, including a write enable of an aborted
  // instruction; the branch decision uses this cycle's ALU flags.
  always_comb begin
    ctrl_o = reset ? '0 : ctrl_q;
  end

  assign bus.ir_write      = ctrl_o.ir_write;
  assign bus.pc_update     = ctrl_o.pc_update;
  assign bus.pc_src        = ctrl_o.jump | (ctrl_o.branch & br_taken);
  assign bus.reg_write     = ctrl_o.reg_write;
  assign bus.mem_write     = ctrl_o.mem_write;
  assign bus.alu_src_a     = ctrl_o.alu_src_a;
  assign bus.alu_src_b     = ctrl_o.alu_src_b;
  assign bus.alu_control   = ctrl_o.alu_control;
  assign bus.result_src    = ctrl_o.result_src;
  assign bus.retire        = ctrl_o.retire;
  assign bus.illegal_instr = ctrl_o.illegal;
  assign bus.instret       = reset ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Scoreboard bench: each instruction pushes its expected per-cycle control
//   words when driven; they are popped and compared once per cycle. A small
//   PC model follows pc_update/pc_src like the datapath would.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  localparam int INSTRET_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.INSTRET_W(INSTRET_W)) bus ();

  multicycle_control_fsm #(.INSTRET_W(INSTRET_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [31:0] exp_instret;
  logic [31:0] imm_cur;
  logic [31:0] pc_model;
  logic        lat_rst = 1'b1;
  logic        lat_pcu = 1'b0;
  logic        lat_pcs = 1'b0;

  // Datapath PC: sample controls mid-cycle, apply at the next rising edge
  always @(negedge clk) begin
    lat_rst <= reset;
    lat_pcu <= bus.pc_update;
    lat_pcs <= bus.pc_src;
  end

  always @(posedge clk) begin
    if (lat_rst)      pc_model <= 32'd0;
    else if (lat_pcu) pc_model <= lat_pcs ? pc_model + imm_cur : pc_model + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, expv);
    end
  endtask

  function automatic logic [16:0] cw(input logic ir, input logic pcu, input logic pcs,
                                     input logic rw, input logic mw, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [3:0] alu,
                                     input logic [1:0] rs, input logic ret, input logic ill);
    return {ir, pcu, pcs, rw, mw, sa, sb, alu, rs, ret, ill};
  endfunction

  function automatic logic [16:0] dut_word();
    return {bus.ir_write, bus.pc_update, bus.pc_src, bus.reg_write, bus.mem_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.result_src,
            bus.retire, bus.illegal_instr};
  endfunction

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 4'd1 : 4'd0;
      3'b001:  return 4'd5;
      3'b010:  return 4'd8;
      3'b011:  return 4'd9;
      3'b100:  return 4'd4;
      3'b101:  return f7 ? 4'd7 : 4'd6;
      3'b110:  return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic z,
                                     input logic lt, input logic ltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      default: return !ltu;
    endcase
  endfunction

  // Called at posedge+1; ends at posedge+1 of the following cycle
  task automatic step_check(input string tag);
    logic [16:0] e;
    @(negedge clk);
    e = exp_q.pop_front();
    chk(tag, {15'd0, dut_word()}, {15'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic lt, input logic ltu, input logic [31:0] imm);
    bus.opcode        = op;
    bus.funct3        = f3;
    bus.funct7_5      = f7;
    bus.alu_zero_flag = z;
    bus.alu_lt_flag   = lt;
    bus.alu_ltu_flag  = ltu;
    imm_cur           = imm;
  endtask

  // Legal instruction, started in its FETCH cycle
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input logic lt, input logic ltu,
                           input logic [31:0] imm);
    logic [31:0] pc_start;
    logic [31:0] pc_exp;
    logic        tk;
    pc_start = pc_model;
    pc_exp   = pc_start + 32'd4;
    drive(op, f3, f7, z, lt, ltu, imm);
    exp_q.push_back(cw(1, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 0));
    exp_q.push_back('0);
    case (op)
      OP_R: begin
        exp_q.push_back(cw(0, 0, 0, 0, 0, 2'd0, 2'd0, ref_alu(f3, f7, 1'b1), 2'd0, 0, 0));
        exp_q.push_back(cw(0, 1, 0, 1, 0, 2'd0, 2'd0, 4'd0, 2'd0, 1, 0));
      end
      OP_IMM: begin
        exp_q.push_back(cw(0, 0, 0, 0, 0, 2'd0, 2'd1, ref_alu(f3, f7, 1'b0), 2'd0, 0, 0));
        exp_q.push_back(cw(0, 1, 0, 1, 0, 2'd0, 2'd0, 4'd0, 2'd0, 1, 0));
      end
      OP_LUI: begin
        exp_q.push_back(cw(0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, 2'd0, 0, 0));
        exp_q.push_back(cw(0, 1, 0, 1, 0, 2'd0, 2'd0, 4'd0, 2'd0, 1, 0));
      end
      OP_LOAD: begin
        exp_q.push_back(cw(0, 0, 0, 0, 0, 2'd0, 2'd1, 4'd0, 2'd0, 0, 0));
        exp_q.push_back('0);
        exp_q.push_back(cw(0, 1, 0, 1, 0, 2'd0, 2'd0, 4'd0, 2'd1, 1, 0));
      end
      OP_STORE: begin
        exp_q.push_back(cw(0, 0, 0, 0, 0, 2'd0, 2'd1, 4'd0, 2'd0, 0, 0));
        exp_q.push_back(cw(0, 1, 0, 0, 1, 2'd0, 2'd0, 4'd0, 2'd0, 1, 0));
      end
      OP_BRANCH: begin
        tk = ref_taken(f3, z, lt, ltu);
        exp_q.push_back(cw(0, 1, tk, 0, 0, 2'd0, 2'd0, 4'd1, 2'd0, 1, 0));
        if (tk) pc_exp = pc_start + imm;
      end
      default: begin
        exp_q.push_back(cw(0, 1, 1, 1, 0, 2'd0, 2'd0, 4'd0, 2'd2, 1, 0));
        pc_exp = pc_start + imm;
      end
    endcase
    exp_instret = exp_instret + 32'd1;
    while (exp_q.size() > 0) step_check(tag);
    chk({tag, "_pc"}, pc_model, pc_exp);
    chk({tag, "_instret"}, bus.instret, exp_instret);
  endtask

  task automatic run_fault(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input int n_fault);
    logic [31:0] pc_start;
    pc_start = pc_model;
    drive(op, f3, 1'b0, 1'b1, 1'b1, 1'b1, 32'd64);
    exp_q.push_back(cw(1, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 0));
    exp_q.push_back('0);
    for (int i = 0; i < n_fault; i++)
      exp_q.push_back(cw(0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 1));
    while (exp_q.size() > 0) step_check(tag);
    chk({tag, "_pc"}, pc_model, pc_start);
    chk({tag, "_instret"}, bus.instret, exp_instret);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_word"}, {15'd0, dut_word()}, 32'd0);
    chk({tag, "_instret"}, bus.instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_instret = 32'd0;
    chk({tag, "_pc"}, pc_model, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    exp_instret = 32'd0;
    drive(7'h7F, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    do_reset("reset");

    // beq x4,x4,-12 taken; beq x1,x2,16 not taken
    run_instr("beq_taken", OP_BRANCH, F3_BEQ, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF4);
    do_reset("reset2");
    run_instr("beq_not", OP_BRANCH, F3_BEQ, 1'b0, 1'b0, 1'b1, 1'b1, 32'd16);
    // sub x1,x1,x1 with zero result must not redirect
    run_instr("sub_zero", OP_R, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 32'd100);
    // x1=-1, x2=1
    run_instr("blt", OP_BRANCH, F3_BLT, 1'b0, 1'b0, 1'b1, 1'b0, 32'd32);
    run_instr("bgeu", OP_BRANCH, F3_BGEU, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFE0);
    run_instr("bne_not", OP_BRANCH, F3_BNE, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8);
    run_instr("bge_not", OP_BRANCH, F3_BGE, 1'b0, 1'b0, 1'b1, 1'b0, 32'd8);
    run_instr("bltu_not", OP_BRANCH, F3_BLTU, 1'b0, 1'b0, 1'b1, 1'b0, 32'd8);
    run_instr("bge_tk", OP_BRANCH, F3_BGE, 1'b0, 1'b1, 1'b0, 1'b1, 32'd12);
    // loads/stores
    run_instr("lw", OP_LOAD, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
    run_instr("sw", OP_STORE, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
    // ALU operation decode
    run_instr("add", OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("addi_f7", OP_IMM, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("srai", OP_IMM, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("srl", OP_R, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("xor", OP_R, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("sltu", OP_R, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("slti", OP_IMM, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("sll", OP_R, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("ori", OP_IMM, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("and", OP_R, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("lui", OP_LUI, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    run_instr("jal", OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd8);

    // Reset asserted during MEM_WR aborts the store
    drive(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10);
    exp_q.push_back(cw(1, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 2'd0, 0, 0));
    exp_q.push_back('0);
    exp_q.push_back(cw(0, 0, 0, 0, 0, 2'd0, 2'd1, 4'd0, 2'd0, 0, 0));
    while (exp_q.size() > 0) step_check("sw_abort");
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("abort_word", {15'd0, dut_word()}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_instret = 32'd0;
    chk("abort_pc", pc_model, 32'd0);
    chk("abort_instret", bus.instret, 32'd0);
    run_instr("after_abort", OP_IMM, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Unsupported opcode, sticky until reset
    run_fault("op7f", 7'h7F, 3'b000, 6);
    do_reset("reset3");
    run_instr("after_fault", OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    // Illegal branch funct3
    run_fault("br_f3_010", OP_BRANCH, 3'b010, 3);
    do_reset("reset4");
    run_fault("br_f3_011", OP_BRANCH, 3'b011, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
